// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage data-memory access controller. Turns load/store
//             control plus the ALU byte address into a req/ack bus
//             transaction, aligns and extends load data, reports faults and
//             stalls the pipeline until the access has completed.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset        : rising-edge clock, asynchronous active-high reset
//    mem_read_in       : load request from EX/MEM
//    mem_write_in      : store request from EX/MEM (wins over mem_read_in)
//    funct3_in         : RV32I load/store funct3 (size / sign)
//    addr_in           : byte address
//    store_data_in     : store data (rs2)
//    dmem_req/we/addr/wdata/be : registered bus request, held while BUSY
//    dmem_rdata, dmem_ack      : bus read data and one-cycle completion
//    read_data_out     : extended load result (0 after a store or fault)
//    stall_out         : hold the front of the pipeline
//    done_out          : one-cycle completion pulse
//    err_out           : 0 none, 1 misaligned, 2 illegal funct3, 3 timeout
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] read_data_out,
  output logic        stall_out,
  output logic        done_out,
  output logic [1:0]  err_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;

  // --------------------------------------------------------------------------
  // Request decode (from EX/MEM inputs)
  // --------------------------------------------------------------------------
  logic        w_mem_op;
  logic        w_legal;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_mem_op = mem_read_in | mem_write_in;

  always_comb begin
    w_legal = 1'b0;
    case (funct3_in)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~mem_write_in;  // unsigned forms are load-only
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_misaligned = ((funct3_in[1:0] == 2'b01) &  addr_in[0]) |
                        ((funct3_in[1:0] == 2'b10) & |addr_in[1:0]);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr_in[1:0];
        w_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        w_be    = addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load extraction using the lane and size latched at request time
  // --------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (lane_q)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
  end

  assign w_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_load = dmem_rdata;
    case (f3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    lane_d  = lane_q;

    case (state_q)
      S_IDLE: begin
        if (w_mem_op) begin
          if (!w_legal) begin
            err_d   = 2'd2;
            rdata_d = 32'd0;
            state_d = S_DONE;
          end else if (w_misaligned) begin
            err_d   = 2'd1;
            rdata_d = 32'd0;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = mem_write_in;
            addr_d  = {addr_in[31:2], 2'b00};
            wdata_d = w_wdata;
            be_d    = w_be;
            f3_d    = funct3_in;
            lane_d  = addr_in[1:0];
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        // An ack in the final timeout cycle still completes the access.
        if (dmem_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : w_load;
          err_d   = 2'd0;
          state_d = S_DONE;
        end else if (cnt_q == C_CNT_LAST) begin
          req_d   = 1'b0;
          rdata_d = 32'd0;
          err_d   = 2'd3;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 2'd0;
      cnt_q   <= '0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign read_data_out = rdata_q;
  assign err_out       = err_q;
  assign done_out      = (state_q == S_DONE);
  assign stall_out     = ((state_q == S_IDLE) & w_mem_op) | (state_q == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit: directed scenarios
//             followed by random load/store traffic compared against an
//             arithmetic reference model of the access rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int C_TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] read_data_out;
  logic        stall_out;
  logic        done_out;
  logic [1:0]  err_out;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(
    .TIMEOUT_CYCLES(C_TIMEOUT),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .funct3_in    (funct3_in),
    .addr_in      (addr_in),
    .store_data_in(store_data_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .read_data_out(read_data_out),
    .stall_out    (stall_out),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: access rules expressed with plain arithmetic
  // --------------------------------------------------------------------------
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] m_err(input logic wr, input logic [2:0] f3,
                                       input logic [31:0] addr);
    bit legal;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 2'd2;
    if ((addr % size_bytes(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int mask;
    mask = ((1 << size_bytes(f3)) - 1) << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_bytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    longint nb;
    longint v;
    nb = 8 * size_bytes(f3);
    v  = longint'(rdata >> (8 * (addr % 4))) & ((64'd1 << nb) - 1);
    if (f3[2] == 1'b0 && nb < 32 && v >= (64'd1 << (nb - 1)))
      v = v - (64'd1 << nb);
    return v[31:0];
  endfunction

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    funct3_in     = 3'd0;
    addr_in       = 32'd0;
    store_data_in = 32'd0;
    dmem_ack      = 1'b0;
    dmem_rdata    = 32'd0;
  endtask

  // One complete access, starting just after an edge with the DUT idle.
  // ack_delay = BUSY cycle index (0-based) on which ack is given.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input int ack_delay,
                            input logic [31:0] rdata);
    logic [1:0] e_err;
    int stall_cnt;
    e_err = m_err(wr, f3, addr);
    mem_read_in   = rd;
    mem_write_in  = wr;
    funct3_in     = f3;
    addr_in       = addr;
    store_data_in = sdata;
    #1;
    check({tag, ".idle_stall"}, 32'(stall_out), 32'd1);
    check({tag, ".idle_req"}, 32'(dmem_req), 32'd0);
    stall_cnt = 1;
    tick();
    if (e_err == 2'd0) begin
      check({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
      check({tag, ".we"}, 32'(dmem_we), 32'(wr));
      check({tag, ".be"}, 32'(dmem_be), 32'(m_be(f3, addr)));
      if (wr) check({tag, ".wdata"}, dmem_wdata, m_wdata(f3, sdata));
      for (int i = 0; i <= ack_delay; i++) begin
        check({tag, ".busy_req"}, 32'(dmem_req), 32'd1);
        if (stall_out) stall_cnt++;
        if (i == ack_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
      end
      check({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(ack_delay + 2));
      check({tag, ".rdata"}, read_data_out, wr ? 32'd0 : m_load(f3, addr, rdata));
    end else begin
      check({tag, ".rdata"}, read_data_out, 32'd0);
    end
    check({tag, ".done"}, 32'(done_out), 32'd1);
    check({tag, ".err"}, 32'(err_out), 32'(e_err));
    check({tag, ".done_stall"}, 32'(stall_out), 32'd0);
    check({tag, ".done_req"}, 32'(dmem_req), 32'd0);
    tick();
    clear_inputs();
    #1;
    check({tag, ".back_idle"}, 32'(done_out), 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    clear_inputs();
    reset = 1'b1;
    #12;
    check("rst.req",   32'(dmem_req), 32'd0);
    check("rst.we",    32'(dmem_we), 32'd0);
    check("rst.addr",  dmem_addr, 32'd0);
    check("rst.wdata", dmem_wdata, 32'd0);
    check("rst.be",    32'(dmem_be), 32'd0);
    check("rst.rdata", read_data_out, 32'd0);
    check("rst.err",   32'(err_out), 32'd0);
    check("rst.done",  32'(done_out), 32'd0);
    reset = 1'b0;
    tick();

    // Non-memory instructions pass straight through.
    for (int i = 0; i < 5; i++) begin
      check("nop.stall", 32'(stall_out), 32'd0);
      check("nop.req",   32'(dmem_req), 32'd0);
      check("nop.done",  32'(done_out), 32'd0);
      tick();
    end

    run_access("lw",  1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'd0, 1, 32'hDEAD_BEEF);
    run_access("lb",  1'b1, 1'b0, 3'b000, 32'h1000_0003, 32'd0, 0, 32'h8012_3456);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h1000_0003, 32'd0, 0, 32'h8012_3456);
    run_access("sh",  1'b0, 1'b1, 3'b001, 32'h2000_0002, 32'h0000_ABCD, 0, 32'd0);
    run_access("rw_store", 1'b1, 1'b1, 3'b000, 32'h2000_0001, 32'h0000_0055, 1, 32'hFFFF_FFFF);
    run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h1000_0002, 32'd0, 0, 32'd0);
    run_access("f3_011", 1'b1, 1'b0, 3'b011, 32'h1000_0000, 32'd0, 0, 32'd0);
    run_access("sbu_ill", 1'b0, 1'b1, 3'b100, 32'h1000_0000, 32'd0, 0, 32'd0);
    run_access("ill_pri", 1'b1, 1'b0, 3'b111, 32'h1000_0003, 32'd0, 0, 32'd0);

    // Timeout: no ack, request held for exactly C_TIMEOUT cycles.
    mem_read_in = 1'b1;
    funct3_in   = 3'b010;
    addr_in     = 32'h3000_0000;
    tick();
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      tick();
    end
    check("to.req_cycles", 32'(n), 32'(C_TIMEOUT));
    check("to.done",  32'(done_out), 32'd1);
    check("to.err",   32'(err_out), 32'd3);
    check("to.rdata", read_data_out, 32'd0);
    tick();
    clear_inputs();

    // Ack arriving in the last timeout cycle wins.
    run_access("ack_last", 1'b1, 1'b0, 3'b001, 32'h3000_0006, 32'd0, C_TIMEOUT - 1,
               32'h9234_5678);

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_access("rnd", rd, wr, f3, a, $urandom, int'($urandom_range(0, C_TIMEOUT - 1)),
                 $urandom);
    end

    // Asynchronous reset in the middle of BUSY.
    mem_read_in = 1'b1;
    funct3_in   = 3'b010;
    addr_in     = 32'h4000_0004;
    tick();
    check("rb.req_before", 32'(dmem_req), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rb.req_async", 32'(dmem_req), 32'd0);
    clear_inputs();
    #1;
    reset = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      check("rb.done",  32'(done_out), 32'd0);
      check("rb.req",   32'(dmem_req), 32'd0);
      check("rb.stall", 32'(stall_out), 32'd0);
      check("rb.rdata", read_data_out, 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts load/store control plus ALU address into a request/acknowledge data-memory transaction.
- Aligns and sign/zero-extends load data into read_data_out; detects faults.
- Stalls the pipeline until the access completes; read_data_out feeds MEM/WB read_data_in.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles without dmem_ack before abort; legal range 1..2^CNT_W-1
CNT_W, 8, width of the timeout counter

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
mem_read_in  input  1  load request from EX/MEM
mem_write_in  input  1  store request from EX/MEM
funct3_in  input  3  access size/sign (RV32I load/store funct3)
addr_in  input  32  byte address (ALU result)
store_data_in  input  32  store data (rs2)
dmem_req  output  1  bus request, held until ack or abort
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_rdata  input  32  read data, valid with dmem_ack
dmem_ack  input  1  single-cycle completion pulse
read_data_out  output  32  extended load result
stall_out  output  1  hold PC, IF/ID, ID/EX and EX/MEM
done_out  output  1  access complete this cycle (one-cycle pulse)
err_out  output  2  0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout; valid when done_out=1

Behaviour:
- Reset (asynchronous, immediate, any state including BUSY): state=IDLE; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; dmem_be=0; read_data_out=0; err_out=0; done_out=0; timeout counter=0. Asserting reset during BUSY drops dmem_req immediately; a later dmem_ack is ignored in IDLE.
- States:
  - IDLE: mem_op = mem_read_in | mem_write_in. If mem_op=0: stall_out=0 and no state change; non-memory instructions pass with zero added latency.
  - If mem_op=1 and legal and aligned: latch funct3, addr[1:0] and operation type; drive registered bus outputs (dmem_req=1); counter=0; go to BUSY.
  - If mem_op=1 and faulting: no bus request; set err_out; go to DONE.
  - BUSY: bus outputs held stable.
    - dmem_ack=1: dmem_req=0; on a load, capture the extended read into read_data_out; err_out=0; go to DONE.
    - Otherwise, if counter==TIMEOUT_CYCLES-1: dmem_req=0; err_out=3; read_data_out=0; go to DONE.
    - Otherwise counter+1.
    - An ack arriving in the timeout cycle wins.
  - DONE: done_out=1, stall_out=0 (the pipeline advances and MEM/WB captures read_data_out); always go to IDLE next cycle.
- stall_out = (IDLE & mem_op) | BUSY. Combinational from state and inputs.
- Read/write priority: mem_write_in=1 with mem_read_in=1 is treated as a store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else gives err 2. Illegal-size check has priority over the alignment check.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00 → err 1.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
  - Driven for loads as well; dmem_we=0 on loads.
- Store data: byte replicated ×4; half replicated ×2; word as is.
- Load extract: select lane using latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- On a store completion or fault, read_data_out is set to 0.
- Minimum latency of a clean access: 3 cycles (IDLE, BUSY with ack, DONE). Faults take 2 cycles (IDLE, DONE).

Test Plan:
- Non-memory ops (mem_read_in=mem_write_in=0) for 5 cycles → stall_out=0, dmem_req=0, done_out=0 throughout.
- LW addr 0x1000_0008, ack after 2 BUSY cycles with rdata 0xDEAD_BEEF:
  - dmem_addr=0x1000_0008, be=1111, we=0.
  - stall_out high 3 cycles.
  - DONE cycle: read_data_out=0xDEAD_BEEF, err_out=0.
- LB addr 0x...03 with rdata 0x80_12_34_56 → read_data_out=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH addr 0x...02, store_data 0x0000_ABCD → dmem_we=1, be=1100, wdata=0xABCD_ABCD, ack immediate → done_out on the following cycle.
- Faulting accesses, with no dmem_req ever asserted in any case:
  - LW addr 0x...02 → err_out=1 in DONE.
  - funct3=011 → err_out=2.
- Timeout and reset:
  - TIMEOUT_CYCLES=4, no ack → dmem_req high exactly 4 cycles, then DONE with err_out=3.
  - Separate run: assert reset mid-BUSY → dmem_req falls without waiting for a clock edge. A subsequent ack is ignored and the unit stays IDLE.
